// File: rtl/shift_reg_param_if.sv
// Bus bundle for shift_reg_param: control strobes, serial/parallel data, status.
// The design drives only the slave-side outputs; the master side is the user logic.
interface shift_reg_param_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 12
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   en;
  logic                   dir;
  logic [WIDTH-1:0]       sin;
  logic                   load;
  logic [WIDTH*DEPTH-1:0] pin;
  logic                   start;
  logic [CW-1:0]          burst_len;
  logic                   rot;
  logic [WIDTH*DEPTH-1:0] pout;
  logic [WIDTH-1:0]       sout_l;
  logic [WIDTH-1:0]       sout_r;
  logic [CW-1:0]          fill;
  logic                   full;
  logic                   busy;
  logic                   done;
  logic [1:0]             state_dbg;

  modport master (
    output en, dir, sin, load, pin, start, burst_len, rot,
    input  pout, sout_l, sout_r, fill, full, busy, done, state_dbg
  );

  modport slave (
    input  en, dir, sin, load, pin, start, burst_len, rot,
    output pout, sout_l, sout_r, fill, full, busy, done, state_dbg
  );
endinterface

// File: rtl/shift_reg_param.sv
// Bidirectional DEPTH x WIDTH shift register with parallel load, fill tracking
// and a burst-shift engine. Define SHIFT_REG_ROTATE_EN to enable rotate shifts.
//
// Handshake: start is a one-cycle request accepted only in IDLE with a legal
// burst_len (1..DEPTH); busy is high for the N shift cycles, done pulses once
// in the cycle after the last shift; load always wins and cancels a burst.
module shift_reg_param #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 12
) (
  input  logic            clk,
  input  logic            clr,
  shift_reg_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [DEPTH-1:0][WIDTH-1:0] shifted;
  logic [CW-1:0]               fill;
  logic [CW-1:0]               fill_next;
  logic [CW-1:0]               cnt;
  logic                        bdir;
  logic                        busy;
  logic                        done;
  logic                        step_dir;
  logic                        do_shift;
  logic                        rot_shift;
  logic                        len_ok;
  logic [WIDTH-1:0]            enter;

`ifdef SHIFT_REG_ROTATE_EN
  logic brot;
`else
  logic unused_rot;
  assign unused_rot = bus.rot;
`endif

  // During a burst the latched direction/rotate select drive the shift.
  always_comb begin
    step_dir  = (state == RUN) ? bdir : bus.dir;
    do_shift  = (state == RUN) || bus.en;
    rot_shift = 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
    rot_shift = (state == RUN) ? brot : bus.rot;
`endif
    enter = bus.sin;
    if (rot_shift) enter = step_dir ? q[0] : q[DEPTH-1];
    if (!step_dir) shifted = {q[DEPTH-2:0], enter};
    else           shifted = {enter, q[DEPTH-1:1]};
    fill_next = (rot_shift || fill == CW'(DEPTH)) ? fill : fill + CW'(1);
    len_ok    = (bus.burst_len != '0) && (bus.burst_len <= CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      q     <= '0;
      fill  <= '0;
      cnt   <= '0;
      bdir  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
      brot  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (bus.load) begin
        q     <= bus.pin;
        fill  <= CW'(DEPTH);
        cnt   <= '0;
        busy  <= 1'b0;
        state <= IDLE;
      end else begin
        if (do_shift) begin
          q    <= shifted;
          fill <= fill_next;
        end
        case (state)
          IDLE: begin
            if (bus.start && len_ok) begin
              cnt   <= bus.burst_len;
              bdir  <= bus.dir;
`ifdef SHIFT_REG_ROTATE_EN
              brot  <= bus.rot;
`endif
              busy  <= 1'b1;
              state <= RUN;
            end
          end
          RUN: begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pout      = q;
  assign bus.sout_l    = q[DEPTH-1];
  assign bus.sout_r    = q[0];
  assign bus.fill      = fill;
  assign bus.full      = (fill == CW'(DEPTH));
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_shift_reg_param.sv
// Self-checking bench for shift_reg_param: directed scenarios plus a randomized
// run compared each cycle against a queue-based behavioural model.
module tb_shift_reg_param;
  localparam int W  = 1;
  localparam int D  = 12;
  localparam int CW = $clog2(D + 1);
  localparam int PW = W * D;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  shift_reg_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  shift_reg_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: stage 0 at the front of the queue
  logic [W-1:0] exp_q[$];
  int           m_fill;
  int           m_left;
  bit           m_bdir;
  bit           m_brot;
  bit           m_done;

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < D; i++) exp_q.push_back('0);
    m_fill = 0;
    m_left = 0;
    m_bdir = 0;
    m_brot = 0;
    m_done = 0;
  endfunction

  function automatic void model_step();
    bit           d;
    bit           r;
    bit           shift_now;
    bit           next_done;
    logic [W-1:0] ent;
    d = 0; r = 0; shift_now = 0; next_done = 0;
    if (bus.load) begin
      exp_q.delete();
      for (int i = 0; i < D; i++) exp_q.push_back(bus.pin[i*W +: W]);
      m_fill = D;
      m_left = 0;
      m_done = 0;
      return;
    end
    if (m_left > 0) begin
      shift_now = 1; d = m_bdir; r = m_brot;
      m_left--;
      next_done = (m_left == 0);
    end else begin
      if (bus.en) begin
        shift_now = 1; d = bus.dir; r = bus.rot;
      end
      if (bus.start && !m_done && bus.burst_len >= 1 && int'(bus.burst_len) <= D) begin
        m_left = int'(bus.burst_len);
        m_bdir = bus.dir;
        m_brot = bus.rot;
      end
    end
    if (shift_now) begin
`ifndef SHIFT_REG_ROTATE_EN
      r = 0;
`endif
      ent = r ? (d ? exp_q[0] : exp_q[D-1]) : bus.sin;
      if (!d) begin
        exp_q.push_front(ent);
        void'(exp_q.pop_back());
      end else begin
        exp_q.push_back(ent);
        void'(exp_q.pop_front());
      end
      if (!r && m_fill < D) m_fill++;
    end
    m_done = next_done;
  endfunction

  function automatic logic [PW-1:0] exp_pout();
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = exp_q[i];
    return v;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.en = 0; bus.dir = 0; bus.sin = '0; bus.load = 0; bus.pin = '0;
    bus.start = 0; bus.burst_len = '0; bus.rot = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    bus.load = 1; bus.pin = PW'(12'hFFF);
    tick();
    bus.load = 0; bus.start = 1; bus.burst_len = CW'(6); bus.dir = 0; bus.sin = 1;
    tick();
    bus.start = 0;
    tick();
    #2;
    clr = 1'b1;
    #1;
    total++;
    if (bus.pout !== '0) begin bad++; $display("FAIL reset_pout got=%h exp=0", bus.pout); end
    total++;
    if (bus.fill !== '0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", bus.fill); end
    total++;
    if ({bus.full, bus.busy, bus.done} !== 3'b000) begin
      bad++; $display("FAIL reset_status got=%b exp=000", {bus.full, bus.busy, bus.done});
    end
    clr = 1'b0;
    model_reset();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        bad++; $display("FAIL reset_no_done cyc=%0d got=%b exp=00", i, {bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_fill();
    idle_inputs();
    do_reset();
    bus.en = 1; bus.dir = 0; bus.sin = 1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      bus.sin = 0;
      total++;
      if (int'(bus.fill) !== ((k < D) ? k : D)) begin
        bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, bus.fill, (k < D) ? k : D);
      end
      total++;
      if (bus.full !== (k >= D)) begin
        bad++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, bus.full, k >= D);
      end
      total++;
      if (bus.sout_l !== W'(k == D)) begin
        bad++; $display("FAIL fill_sout_l k=%0d got=%h exp=%h", k, bus.sout_l, k == D);
      end
    end
    bus.en = 0;
  endtask

  task automatic test_burst();
    idle_inputs();
    do_reset();
    bus.load = 1; bus.pin = PW'(12'hA5C);
    tick();
    bus.load = 0; bus.start = 1; bus.burst_len = CW'(4); bus.dir = 1; bus.sin = 0;
    tick();
    bus.start = 0; bus.dir = 0; bus.sin = 1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        bad++; $display("FAIL burst_busy cyc=%0d got=%b exp=10", i, {bus.busy, bus.done});
      end
      bus.sin = 0;
      tick();
    end
    total++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      bad++; $display("FAIL burst_done got=%b exp=01", {bus.busy, bus.done});
    end
    total++;
    if (bus.pout !== PW'(12'h0A5)) begin
      bad++; $display("FAIL burst_pout got=%h exp=%h", bus.pout, 12'h0A5);
    end
    bus.start = 1; bus.burst_len = CW'(3);
    tick();
    bus.start = 0;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL burst_done_once got=%b exp=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_abort();
    idle_inputs();
    do_reset();
    bus.load = 1; bus.pin = PW'(12'h3C3);
    tick();
    bus.load = 0; bus.start = 1; bus.burst_len = CW'(6); bus.dir = 0; bus.sin = 1;
    tick();
    bus.start = 0;
    tick();
    bus.load = 1; bus.pin = PW'(12'h5A6);
    tick();
    bus.load = 0;
    total++;
    if (bus.pout !== PW'(12'h5A6)) begin
      bad++; $display("FAIL abort_pout got=%h exp=5a6", bus.pout);
    end
    total++;
    if (int'(bus.fill) !== D) begin bad++; $display("FAIL abort_fill got=%0d exp=%0d", bus.fill, D); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        bad++; $display("FAIL abort_no_done cyc=%0d got=%b exp=00", i, {bus.busy, bus.done});
      end
      tick();
    end
  endtask

  task automatic test_bad_len();
    logic [CW-1:0] lens[2];
    lens[0] = CW'(0);
    lens[1] = CW'(D + 1);
    idle_inputs();
    do_reset();
    bus.load = 1; bus.pin = PW'(12'h9E1);
    tick();
    bus.load = 0;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1; bus.burst_len = lens[i]; bus.dir = i[0];
      tick();
      bus.start = 0;
      tick();
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL badlen_busy len=%0d got=%b exp=0", lens[i], bus.busy); end
      total++;
      if (bus.pout !== PW'(12'h9E1)) begin
        bad++; $display("FAIL badlen_pout len=%0d got=%h exp=9e1", lens[i], bus.pout);
      end
    end
  endtask

  task automatic test_rotate();
    logic [PW-1:0] want;
`ifdef SHIFT_REG_ROTATE_EN
    want = PW'(12'h800);
`else
    want = '0;
`endif
    idle_inputs();
    do_reset();
    bus.load = 1; bus.pin = PW'(12'h001);
    tick();
    bus.load = 0; bus.rot = 1; bus.dir = 1; bus.en = 1; bus.sin = 0;
    tick();
    idle_inputs();
    total++;
    if (bus.pout !== want) begin bad++; $display("FAIL rotate_pout got=%h exp=%h", bus.pout, want); end
    total++;
    if (int'(bus.fill) !== D) begin bad++; $display("FAIL rotate_fill got=%0d exp=%0d", bus.fill, D); end
  endtask

  task automatic test_random();
    idle_inputs();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.load      = ($urandom_range(0, 15) == 0);
      bus.pin       = PW'($urandom);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.burst_len = CW'($urandom_range(0, (1 << CW) - 1));
      bus.en        = $urandom_range(0, 1);
      bus.dir       = $urandom_range(0, 1);
      bus.rot       = $urandom_range(0, 1);
      bus.sin       = W'($urandom);
      tick();
      total++;
      if (bus.pout !== exp_pout()) begin
        bad++; $display("FAIL rand_pout cyc=%0d got=%h exp=%h", c, bus.pout, exp_pout());
      end
      total++;
      if ({bus.sout_l, bus.sout_r} !== {exp_q[D-1], exp_q[0]}) begin
        bad++; $display("FAIL rand_sout cyc=%0d got=%h exp=%h", c, {bus.sout_l, bus.sout_r},
                        {exp_q[D-1], exp_q[0]});
      end
      total++;
      if (int'(bus.fill) !== m_fill) begin
        bad++; $display("FAIL rand_fill cyc=%0d got=%0d exp=%0d", c, bus.fill, m_fill);
      end
      total++;
      if ({bus.full, bus.busy, bus.done} !== {m_fill == D, m_left > 0, m_done}) begin
        bad++; $display("FAIL rand_status cyc=%0d got=%b exp=%b", c, {bus.full, bus.busy, bus.done},
                        {m_fill == D, m_left > 0, m_done});
      end
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    test_reset();
    test_fill();
    test_burst();
    test_abort();
    test_bad_len();
    test_rotate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
